// File: rtl/alu32_selftest.sv
// Built-in self-test sequencer for a 32-bit ALU. It walks an 8-entry vector table,
// holds each vector for SETTLE_CYCLES+1 cycles, then checks y, zero and overflow.
module alu32_selftest #(
    parameter int SETTLE_CYCLES = 1,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_f,
    input  logic [31:0] alu_y,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [2:0]  first_fail,
    output logic [1:0]  state_dbg
);

    // Handshake: start is a level request accepted only in IDLE or DONE (ignored in RUN);
    // done is a level that holds, together with pass/fail_count/first_fail, until the next
    // accepted start or reset.

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
        logic        zero;
        logic        ovf;
        logic        ovf_care;
    } vec_t;

    localparam logic [3:0] settle_max = 4'(SETTLE_CYCLES);

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f, input logic [31:0] y,
                                input logic zero, input logic ovf);
        vec_t v;
        v.a        = a;
        v.b        = b;
        v.f        = f;
        v.y        = y;
        v.zero     = zero;
        v.ovf      = ovf;
        // Overflow is only meaningful for ADD and SUB.
        v.ovf_care = (f == 3'b010) || (f == 3'b110);
        return v;
    endfunction

    function automatic vec_t vec_at(input logic [2:0] i);
        vec_t v;
        case (i)
            3'd0:    v = mk(32'd1,        32'd2,        3'b010, 32'd3,        1'b0, 1'b0);
            3'd1:    v = mk(32'd150000,   32'd5555,     3'b010, 32'd155555,   1'b0, 1'b0);
            3'd2:    v = mk(32'd128,      32'd128,      3'b110, 32'd0,        1'b1, 1'b0);
            3'd3:    v = mk(32'h40000000, 32'h40000000, 3'b010, 32'h80000000, 1'b0, 1'b1);
            3'd4:    v = mk(32'd1,        32'd2,        3'b110, 32'hFFFFFFFF, 1'b0, 1'b0);
            3'd5:    v = mk(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0);
            3'd6:    v = mk(32'hF0000000, 32'h0000000F, 3'b001, 32'hF000000F, 1'b0, 1'b0);
            default: v = mk(32'd5,        32'd7,        3'b111, 32'd1,        1'b0, 1'b0);
        endcase
        return v;
    endfunction

    state_t      state, state_n;
    logic [2:0]  idx, idx_n;
    logic [3:0]  cnt, cnt_n;
    vec_t        drv, drv_n;
    logic        busy_n, done_n, pass_n;
    logic [3:0]  fail_count_n;
    logic [2:0]  first_fail_n;
    logic        mismatch;

    // The driven vector and its expected results live in one register so the compare
    // always uses the expectation that belongs to what is on the ALU inputs.
    assign alu_a     = drv.a;
    assign alu_b     = drv.b;
    assign alu_f     = drv.f;
    assign state_dbg = state;

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        drv_n        = drv;
        busy_n       = busy;
        done_n       = done;
        pass_n       = pass;
        fail_count_n = fail_count;
        first_fail_n = first_fail;
        mismatch     = (alu_y != drv.y) || (alu_zero != drv.zero) ||
                       (drv.ovf_care && (alu_overflow != drv.ovf));

        case (state)
            st_idle, st_done: begin
                if (start) begin
                    state_n      = st_run;
                    idx_n        = 3'd0;
                    cnt_n        = 4'd0;
                    drv_n        = vec_at(3'd0);
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    pass_n       = 1'b0;
                    fail_count_n = 4'd0;
                    first_fail_n = 3'd0;
                end
            end
            st_run: begin
                if (cnt < settle_max) begin
                    cnt_n = cnt + 4'd1;
                end else begin
                    cnt_n = 4'd0;
                    if (mismatch) begin
                        if (fail_count != 4'd8) fail_count_n = fail_count + 4'd1;
                        if (fail_count == 4'd0) first_fail_n = idx;
                    end
                    if ((idx == 3'd7) || (STOP_ON_FAIL && mismatch)) begin
                        state_n = st_done;
                        drv_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (fail_count_n == 4'd0);
                    end else begin
                        idx_n = idx + 3'd1;
                        drv_n = vec_at(idx + 3'd1);
                    end
                end
            end
            default: state_n = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= st_idle;
            idx        <= 3'd0;
            cnt        <= 4'd0;
            drv        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 4'd0;
            first_fail <= 3'd0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            drv        <= drv_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            fail_count <= fail_count_n;
            first_fail <= first_fail_n;
        end
    end

endmodule

// File: tb/tb_alu32_selftest.sv
// Bench for alu32_selftest: three sequencer instances with different parameters, each
// driven into a behavioural ALU with selectable faults, checked against a run-level model.
module tb_alu32_selftest;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [ND];
    logic        start      [ND];
    int          mode       [ND];
    logic [31:0] alu_a      [ND];
    logic [31:0] alu_b      [ND];
    logic [2:0]  alu_f      [ND];
    logic [31:0] alu_y      [ND];
    logic        alu_zero   [ND];
    logic        alu_ovf    [ND];
    logic        busy       [ND];
    logic        done       [ND];
    logic        pass       [ND];
    logic [3:0]  fail_count [ND];
    logic [2:0]  first_fail [ND];
    logic [1:0]  state_dbg  [ND];

    int settle_of [ND] = '{1, 3, 1};
    bit stop_of   [ND] = '{1'b0, 1'b0, 1'b1};

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    alu32_selftest #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) dut0 (
        .clk(clk), .reset(rst[0]), .start(start[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_f(alu_f[0]),
        .alu_y(alu_y[0]), .alu_zero(alu_zero[0]), .alu_overflow(alu_ovf[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_count(fail_count[0]), .first_fail(first_fail[0]), .state_dbg(state_dbg[0]));

    alu32_selftest #(.SETTLE_CYCLES(3), .STOP_ON_FAIL(1'b0)) dut1 (
        .clk(clk), .reset(rst[1]), .start(start[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_f(alu_f[1]),
        .alu_y(alu_y[1]), .alu_zero(alu_zero[1]), .alu_overflow(alu_ovf[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_count(fail_count[1]), .first_fail(first_fail[1]), .state_dbg(state_dbg[1]));

    alu32_selftest #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) dut2 (
        .clk(clk), .reset(rst[2]), .start(start[2]),
        .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_f(alu_f[2]),
        .alu_y(alu_y[2]), .alu_zero(alu_zero[2]), .alu_overflow(alu_ovf[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .fail_count(fail_count[2]), .first_fail(first_fail[2]), .state_dbg(state_dbg[2]));

    // Behavioural ALU. Mode 0 correct, 1 zero flag stuck at 0, 2 overflow stuck at 0 and SLT returns 0.
    function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f, input int m);
        longint s;
        logic [31:0] y;
        logic z, o;
        s = 0;
        y = 32'd0;
        o = 1'b0;
        case (f)
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b010: begin
                s = longint'($signed(a)) + longint'($signed(b));
                y = s[31:0];
                o = (s != longint'($signed(y)));
            end
            3'b110: begin
                s = longint'($signed(a)) - longint'($signed(b));
                y = s[31:0];
                o = (s != longint'($signed(y)));
            end
            3'b111: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: y = 32'd0;
        endcase
        if (m == 2) begin
            o = 1'b0;
            if (f == 3'b111) y = 32'd0;
        end
        z = (y == 32'd0);
        if (m == 1) z = 1'b0;
        return {y, z, o};
    endfunction

    always_comb begin
        for (int n = 0; n < ND; n++)
            {alu_y[n], alu_zero[n], alu_ovf[n]} = alu_fn(alu_a[n], alu_b[n], alu_f[n], mode[n]);
    end

    logic [31:0] tv_a [8] = '{32'd1, 32'd150000, 32'd128, 32'h40000000,
                              32'd1, 32'hF0F0F0F0, 32'hF0000000, 32'd5};
    logic [31:0] tv_b [8] = '{32'd2, 32'd5555, 32'd128, 32'h40000000,
                              32'd2, 32'h0FF00FF0, 32'h0000000F, 32'd7};
    logic [2:0]  tv_f [8] = '{3'b010, 3'b010, 3'b110, 3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [31:0] tv_y [8] = '{32'd3, 32'd155555, 32'd0, 32'h80000000,
                              32'hFFFFFFFF, 32'h00F000F0, 32'hF000000F, 32'd1};
    logic [7:0]  tv_z = 8'b0000_0100;
    logic [7:0]  tv_o = 8'b0000_1000;

    function automatic logic [7:0] predict(input int m);
        logic [7:0] mm;
        logic [33:0] r;
        bit care;
        for (int i = 0; i < 8; i++) begin
            r     = alu_fn(tv_a[i], tv_b[i], tv_f[i], m);
            care  = (tv_f[i] == 3'b010) || (tv_f[i] == 3'b110);
            mm[i] = (r[33:2] != tv_y[i]) || (r[1] != tv_z[i]) || (care && (r[0] != tv_o[i]));
        end
        return mm;
    endfunction

    // Run-level model: phase 0 idle, 1 running, 2 finished. t counts edges since the accepted start.
    int         ph     [ND] = '{0, 0, 0};
    int         t      [ND] = '{0, 0, 0};
    int         end_e  [ND] = '{0, 0, 0};
    int         last_i [ND] = '{0, 0, 0};
    logic [7:0] mm     [ND] = '{8'd0, 8'd0, 8'd0};

    always @(posedge clk) begin
        logic [7:0] m;
        int li;
        for (int n = 0; n < ND; n++) begin
            if (rst[n]) begin
                ph[n] <= 0;
            end else if (ph[n] != 1 && start[n]) begin
                m  = predict(mode[n]);
                li = 7;
                if (stop_of[n])
                    for (int i = 7; i >= 0; i--) if (m[i]) li = i;
                mm[n]     <= m;
                last_i[n] <= li;
                end_e[n]  <= (li + 1) * (settle_of[n] + 1);
                t[n]      <= 0;
                ph[n]     <= 1;
            end else if (ph[n] == 1) begin
                t[n] <= t[n] + 1;
                if (t[n] + 1 == end_e[n]) ph[n] <= 2;
            end
        end
    end

    task automatic check(input string name, input int n, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, n, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int n = 0; n < ND; n++) begin
                logic [31:0] ea, eb;
                logic [2:0] ef, eff;
                logic eb_busy, e_done, e_pass;
                int efc, s, vi;
                ea = 0; eb = 0; ef = 0; eff = 0; eb_busy = 0; e_done = 0; e_pass = 0; efc = 0;
                s = settle_of[n] + 1;
                if (ph[n] == 1) begin
                    vi = t[n] / s;
                    ea = tv_a[vi]; eb = tv_b[vi]; ef = tv_f[vi];
                    eb_busy = 1'b1;
                    for (int i = 0; i < 8; i++)
                        if (mm[n][i] && (i + 1) * s <= t[n]) begin
                            if (efc == 0) eff = 3'(i);
                            efc++;
                        end
                end else if (ph[n] == 2) begin
                    e_done = 1'b1;
                    for (int i = 0; i <= last_i[n]; i++)
                        if (mm[n][i]) begin
                            if (efc == 0) eff = 3'(i);
                            efc++;
                        end
                    e_pass = (efc == 0);
                end
                check("alu_a", n, alu_a[n], ea);
                check("alu_b", n, alu_b[n], eb);
                check("alu_f", n, 32'(alu_f[n]), 32'(ef));
                check("busy", n, 32'(busy[n]), 32'(eb_busy));
                check("done", n, 32'(done[n]), 32'(e_done));
                check("pass", n, 32'(pass[n]), 32'(e_pass));
                check("fail_count", n, 32'(fail_count[n]), 32'(efc));
                check("first_fail", n, 32'(first_fail[n]), 32'(eff));
                check("state", n, 32'(state_dbg[n]), 32'(ph[n]));
            end
        end
    end

    task automatic pulse(input int n);
        @(negedge clk);
        start[n] = 1'b1;
        @(posedge clk);
        #1;
        start[n] = 1'b0;
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int n = 0; n < ND; n++) begin
            rst[n] = 1'b1; start[n] = 1'b0; mode[n] = 0;
        end
        step(3);
        for (int n = 0; n < ND; n++) rst[n] = 1'b0;
        chk_en = 1'b1;
        check("lit_rst_busy", 0, 32'(busy[0]), 32'd0);
        check("lit_rst_alu_a", 0, alu_a[0], 32'd0);

        // Correct ALU, full run: busy through E15, done/pass at E16.
        pulse(0);
        check("lit_e0_alu_a", 0, alu_a[0], 32'd1);
        step(15);
        check("lit_e15_busy", 0, 32'(busy[0]), 32'd1);
        check("lit_e15_done", 0, 32'(done[0]), 32'd0);
        step(1);
        check("lit_e16_done", 0, 32'(done[0]), 32'd1);
        check("lit_e16_pass", 0, 32'(pass[0]), 32'd1);

        // Zero flag stuck low: only vector 2 fails.
        mode[0] = 1;
        pulse(0);
        step(16);
        check("lit_zero_fc", 0, 32'(fail_count[0]), 32'd1);
        check("lit_zero_ff", 0, 32'(first_fail[0]), 32'd2);
        check("lit_zero_pass", 0, 32'(pass[0]), 32'd0);

        // Overflow stuck and SLT broken: vectors 3 and 7 fail.
        mode[0] = 2;
        pulse(0);
        step(16);
        check("lit_ovf_fc", 0, 32'(fail_count[0]), 32'd2);
        check("lit_ovf_ff", 0, 32'(first_fail[0]), 32'd3);

        // Restart from a failed DONE with a healthy ALU.
        mode[0] = 0;
        pulse(0);
        check("lit_restart_fc", 0, 32'(fail_count[0]), 32'd0);
        check("lit_restart_done", 0, 32'(done[0]), 32'd0);
        step(16);
        check("lit_restart_pass", 0, 32'(pass[0]), 32'd1);

        // Stop-on-fail variant finishes at E8.
        mode[2] = 2;
        pulse(2);
        step(7);
        check("lit_stop_e7_done", 2, 32'(done[2]), 32'd0);
        step(1);
        check("lit_stop_e8_done", 2, 32'(done[2]), 32'd1);
        check("lit_stop_fc", 2, 32'(fail_count[2]), 32'd1);
        check("lit_stop_ff", 2, 32'(first_fail[2]), 32'd3);

        // Start re-pulsed at E5 is ignored.
        pulse(0);
        step(4);
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(11);
        check("lit_repulse_done", 0, 32'(done[0]), 32'd1);

        // Reset at E9 aborts the run.
        pulse(0);
        step(8);
        rst[0] = 1'b1;
        step(1);
        check("lit_abort_busy", 0, 32'(busy[0]), 32'd0);
        check("lit_abort_alu_a", 0, alu_a[0], 32'd0);
        check("lit_abort_state", 0, 32'(state_dbg[0]), 32'd0);
        rst[0] = 1'b0;

        // SETTLE_CYCLES=3: vector 1 held E4..E7, done at E32.
        pulse(1);
        step(3);
        check("lit_s3_e3_alu_a", 1, alu_a[1], 32'd1);
        for (int k = 4; k < 8; k++) begin
            step(1);
            check("lit_s3_hold_alu_a", 1, alu_a[1], 32'd150000);
        end
        step(1);
        check("lit_s3_e8_alu_a", 1, alu_a[1], 32'd128);
        step(23);
        check("lit_s3_e31_done", 1, 32'(done[1]), 32'd0);
        step(1);
        check("lit_s3_e32_done", 1, 32'(done[1]), 32'd1);

        // Start held high restarts at each DONE.
        mode[2] = 0;
        @(negedge clk);
        start[2] = 1'b1;
        step(40);
        @(negedge clk);
        start[2] = 1'b0;

        // Random phase: faults only change while a run is not in progress.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int n = 0; n < ND; n++) begin
                if (ph[n] != 1 && $urandom_range(0, 3) == 0) mode[n] = int'($urandom_range(0, 2));
                start[n] = ($urandom_range(0, 5) == 0);
                rst[n]   = ($urandom_range(0, 80) == 0);
            end
        end
        @(negedge clk);
        for (int n = 0; n < ND; n++) begin
            start[n] = 1'b0; rst[n] = 1'b0;
        end
        step(40);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
